// File: rtl/thresholding_axilite_loader.sv
// Streams N_WORDS threshold words from AXI-Stream into consecutive AXI-Lite
// word addresses starting at BASE_ADDR, one outstanding write at a time.
`timescale 1ns/1ps
module thresholding_axilite_loader #(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned N_WORDS   = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tvalid,
  input  logic [31:0]          s_axis_tdata,
  output logic                 m_axilite_AWVALID,
  input  logic                 m_axilite_AWREADY,
  output logic [ADDR_BITS-1:0] m_axilite_AWADDR,
  output logic                 m_axilite_WVALID,
  input  logic                 m_axilite_WREADY,
  output logic [31:0]          m_axilite_WDATA,
  output logic [3:0]           m_axilite_WSTRB,
  input  logic                 m_axilite_BVALID,
  output logic                 m_axilite_BREADY,
  input  logic [1:0]           m_axilite_BRESP
);

  localparam int unsigned IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
  localparam logic [ADDR_BITS-1:0] BASE_TRUNC = BASE_ADDR[ADDR_BITS-1:0];

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, RESP} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 tready_q, tready_d;
  logic                 awvalid_q, awvalid_d;
  logic                 wvalid_q, wvalid_d;
  logic                 bready_q, bready_d;
  logic [ADDR_BITS-1:0] awaddr_q, awaddr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [ADDR_BITS-1:0] word_addr;
  logic                 aw_pend, w_pend;

  // Modulo-2^ADDR_BITS addition gives the required truncation for free.
  assign word_addr = BASE_TRUNC + ADDR_BITS'({idx_q, 2'b00});

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      tready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      tready_q  <= tready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    done_d    = 1'b0;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    aw_pend   = 1'b0;
    w_pend    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end
      FETCH: begin
        if (s_axis_tvalid && tready_q) begin
          wdata_d   = s_axis_tdata;
          awaddr_d  = word_addr;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        // Each channel retires on its own ready; BREADY waits for both.
        aw_pend   = awvalid_q && !m_axilite_AWREADY;
        w_pend    = wvalid_q && !m_axilite_WREADY;
        awvalid_d = aw_pend;
        wvalid_d  = w_pend;
        if (!aw_pend && !w_pend) begin
          state_d  = RESP;
          bready_d = 1'b1;
        end
      end
      RESP: begin
        if (m_axilite_BVALID && bready_q) begin
          bready_d = 1'b0;
          if (m_axilite_BRESP != 2'b00) err_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered copies of state decodes keep busy/tready glitch-free.
    tready_d = (state_d == FETCH);
    busy_d   = (state_d != IDLE);
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;
  assign s_axis_tready     = tready_q;
  assign m_axilite_AWVALID = awvalid_q;
  assign m_axilite_AWADDR  = awaddr_q;
  assign m_axilite_WVALID  = wvalid_q;
  assign m_axilite_WDATA   = wdata_q;
  assign m_axilite_WSTRB   = 4'hF;
  assign m_axilite_BREADY  = bready_q;

endmodule

// File: tb/tb_thresholding_axilite_loader.sv
// Bench for thresholding_axilite_loader: a 12-bit/0x40 instance plus a 6-bit/0x38
// instance run in lockstep on shared stimulus to cover address truncation.
`timescale 1ns/1ps
module tb_thresholding_axilite_loader;

  logic ap_clk, ap_rst_n, start;
  logic s_axis_tvalid;
  logic [31:0] s_axis_tdata;
  logic awready, wready, bvalid;
  logic [1:0] bresp;

  logic busy_a, done_a, err_a, tready_a, awvalid_a, wvalid_a, bready_a;
  logic [11:0] awaddr_a;
  logic [31:0] wdata_a;
  logic [3:0]  wstrb_a;
  logic busy_b, done_b, err_b, tready_b, awvalid_b, wvalid_b, bready_b;
  logic [5:0]  awaddr_b;
  logic [31:0] wdata_b;
  logic [3:0]  wstrb_b;

  thresholding_axilite_loader #(.ADDR_BITS(12), .N_WORDS(4), .BASE_ADDR(32'h40)) dut_a (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .busy(busy_a), .done(done_a),
    .err(err_a), .s_axis_tready(tready_a), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata(s_axis_tdata), .m_axilite_AWVALID(awvalid_a), .m_axilite_AWREADY(awready),
    .m_axilite_AWADDR(awaddr_a), .m_axilite_WVALID(wvalid_a), .m_axilite_WREADY(wready),
    .m_axilite_WDATA(wdata_a), .m_axilite_WSTRB(wstrb_a), .m_axilite_BVALID(bvalid),
    .m_axilite_BREADY(bready_a), .m_axilite_BRESP(bresp));

  thresholding_axilite_loader #(.ADDR_BITS(6), .N_WORDS(4), .BASE_ADDR(32'h38)) dut_b (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .busy(busy_b), .done(done_b),
    .err(err_b), .s_axis_tready(tready_b), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata(s_axis_tdata), .m_axilite_AWVALID(awvalid_b), .m_axilite_AWREADY(awready),
    .m_axilite_AWADDR(awaddr_b), .m_axilite_WVALID(wvalid_b), .m_axilite_WREADY(wready),
    .m_axilite_WDATA(wdata_b), .m_axilite_WSTRB(wstrb_b), .m_axilite_BVALID(bvalid),
    .m_axilite_BREADY(bready_b), .m_axilite_BRESP(bresp));

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct {
    string name;
    int aw_dly; int w_dly; int b_dly;
    int err_word; int stall_word; int stall_n; bit poke;
    int exp_lat; bit exp_err; int exp_aw_hi; int exp_w_hi;
    logic [3:0][31:0] dat;
  } vec_t;

  vec_t vecs [6];
  logic [11:0] exp_a [4] = '{12'h040, 12'h044, 12'h048, 12'h04C};
  logic [5:0]  exp_b [4] = '{6'h38, 6'h3C, 6'h00, 6'h04};

  int checks = 0;
  int errors = 0;

  // slave / stream configuration, written only by the main process
  int cfg_aw = 0, cfg_w = 0, cfg_b = 0, cfg_errw = -1, cfg_stw = -1, cfg_stn = 0;
  int s_base = 0, b_base = 0, stall_base = 0;
  logic [3:0][31:0] cur_dat = '0;

  // monitor state, written only by the monitor
  logic [11:0] aw_log_a [256];
  logic [5:0]  aw_log_b [256];
  logic [31:0] w_log    [256];
  int aw_n = 0, w_n = 0, b_n = 0, s_n = 0, done_n = 0, done_nb = 0;
  int aw_hi = 0, w_hi = 0, bready_viol = 0, stable_viol = 0, stall_cyc = 0, stall_act = 0;
  logic hold_aw = 1'b0, hold_w = 1'b0;
  logic [11:0] held_aw = '0;
  logic [31:0] held_w = '0;

  always @(posedge ap_clk) begin
    if (awvalid_a && awready) begin
      aw_log_a[aw_n[7:0]] <= awaddr_a;
      aw_log_b[aw_n[7:0]] <= awaddr_b;
      aw_n <= aw_n + 1;
    end
    if (wvalid_a && wready) begin
      w_log[w_n[7:0]] <= wdata_a;
      w_n <= w_n + 1;
    end
    if (bvalid && bready_a) b_n <= b_n + 1;
    if (s_axis_tvalid && tready_a) s_n <= s_n + 1;
    if (tready_a && !s_axis_tvalid) stall_cyc <= stall_cyc + 1;
    if (tready_a && !s_axis_tvalid && (awvalid_a || wvalid_a)) stall_act <= stall_act + 1;
    if (done_a) done_n <= done_n + 1;
    if (done_b) done_nb <= done_nb + 1;
    if (awvalid_a) aw_hi <= aw_hi + 1;
    if (wvalid_a) w_hi <= w_hi + 1;
    if (bready_a && (awvalid_a || wvalid_a)) bready_viol <= bready_viol + 1;
    if (!ap_rst_n) begin
      hold_aw <= 1'b0;
      hold_w  <= 1'b0;
    end else begin
      if ((hold_aw && awaddr_a != held_aw) || (hold_w && wdata_a != held_w))
        stable_viol <= stable_viol + 1;
      hold_aw <= awvalid_a && !awready;
      hold_w  <= wvalid_a && !wready;
      held_aw <= awaddr_a;
      held_w  <= wdata_a;
    end
  end

  // AW / W / B slaves: ready (or valid) after a configured number of waiting cycles
  initial begin
    int cnt;
    cnt = 0; awready = 1'b0;
    forever begin
      @(negedge ap_clk);
      if (awvalid_a) begin
        if (cnt >= cfg_aw) awready = 1'b1;
        else begin awready = 1'b0; cnt++; end
      end else begin awready = 1'b0; cnt = 0; end
    end
  end

  initial begin
    int cnt;
    cnt = 0; wready = 1'b0;
    forever begin
      @(negedge ap_clk);
      if (wvalid_a) begin
        if (cnt >= cfg_w) wready = 1'b1;
        else begin wready = 1'b0; cnt++; end
      end else begin wready = 1'b0; cnt = 0; end
    end
  end

  initial begin
    int cnt;
    cnt = 0; bvalid = 1'b0; bresp = 2'b00;
    forever begin
      @(negedge ap_clk);
      if (bready_a) begin
        if (cnt >= cfg_b) begin
          bvalid = 1'b1;
          bresp  = ((b_n - b_base) == cfg_errw) ? 2'b10 : 2'b00;
        end else begin bvalid = 1'b0; cnt++; end
      end else begin bvalid = 1'b0; bresp = 2'b00; cnt = 0; end
    end
  end

  initial begin
    int idx;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0;
    forever begin
      @(negedge ap_clk);
      idx = s_n - s_base;
      if (idx >= 0 && idx < 4) begin
        s_axis_tvalid = !(idx == cfg_stw && (stall_cyc - stall_base) < cfg_stn);
        s_axis_tdata  = cur_dat[idx[1:0]];
      end else begin
        s_axis_tvalid = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic arm(input vec_t v);
    cfg_aw = v.aw_dly; cfg_w = v.w_dly; cfg_b = v.b_dly;
    cfg_errw = v.err_word; cfg_stw = v.stall_word; cfg_stn = v.stall_n;
    cur_dat = v.dat;
    s_base = s_n; b_base = b_n; stall_base = stall_cyc;
  endtask

  task automatic pulse_start();
    @(posedge ap_clk); #1 start = 1'b1;
    @(posedge ap_clk); #1 start = 1'b0;
  endtask

  task automatic run_row(input vec_t v);
    int cnt, aw0, w0, b0, d0, db0, awh0, wh0, bv0, sv0, sa0;
    bit poked;
    arm(v);
    aw0 = aw_n; w0 = w_n; b0 = b_n; d0 = done_n; db0 = done_nb;
    awh0 = aw_hi; wh0 = w_hi; bv0 = bready_viol; sv0 = stable_viol; sa0 = stall_act;
    pulse_start();
    cnt = 1;
    chk({v.name, " tready_after_start"}, 64'(tready_a), 64'd1);
    chk({v.name, " err_cleared"}, 64'(err_a), 64'd0);
    poked = 1'b0;
    while (!done_a && cnt < 300) begin
      start = 1'b0;
      if (v.poke && !poked && awvalid_a) begin start = 1'b1; poked = 1'b1; end
      @(posedge ap_clk); #1;
      cnt++;
    end
    start = 1'b0;
    chk({v.name, " done_seen"}, 64'(done_a), 64'd1);
    chk({v.name, " latency"}, 64'(cnt), 64'(v.exp_lat));
    chk({v.name, " busy_at_done"}, 64'(busy_a), 64'd0);
    repeat (3) @(posedge ap_clk);
    #1;
    chk({v.name, " err_sticky"}, 64'(err_a), 64'(v.exp_err));
    chk({v.name, " done_count"}, 64'(done_n - d0), 64'd1);
    chk({v.name, " done_count_b"}, 64'(done_nb - db0), 64'd1);
    chk({v.name, " aw_count"}, 64'(aw_n - aw0), 64'd4);
    chk({v.name, " w_count"}, 64'(w_n - w0), 64'd4);
    chk({v.name, " b_count"}, 64'(b_n - b0), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s awaddr[%0d]", v.name, k), 64'(aw_log_a[8'(aw0 + k)]), 64'(exp_a[k]));
      chk($sformatf("%s awaddr_wrap[%0d]", v.name, k), 64'(aw_log_b[8'(aw0 + k)]), 64'(exp_b[k]));
      chk($sformatf("%s wdata[%0d]", v.name, k), 64'(w_log[8'(w0 + k)]), 64'(v.dat[k]));
    end
    chk({v.name, " awvalid_cycles"}, 64'(aw_hi - awh0), 64'(v.exp_aw_hi));
    chk({v.name, " wvalid_cycles"}, 64'(w_hi - wh0), 64'(v.exp_w_hi));
    chk({v.name, " bready_early"}, 64'(bready_viol - bv0), 64'd0);
    chk({v.name, " held_stable"}, 64'(stable_viol - sv0), 64'd0);
    chk({v.name, " stall_activity"}, 64'(stall_act - sa0), 64'd0);
    $display("load %-8s writes=%0d err=%0d cycles=%0d", v.name, aw_n - aw0, err_a, cnt);
  endtask

  initial begin
    int cnt, aw0, sn0;
    ap_rst_n = 1'b0;
    start = 1'b0;
    //            name      aw w  b  errw stw stn poke lat err awhi whi data
    vecs[0] = '{"basic",    0, 0, 0, -1,  -1, 0,  0,   13, 0,  4,   4, {32'h44, 32'h33, 32'h22, 32'h11}};
    vecs[1] = '{"blag",     0, 0, 1, -1,  -1, 0,  0,   17, 0,  4,   4, {32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 32'h12345678}};
    vecs[2] = '{"skew_aw",  3, 0, 0, -1,  -1, 0,  0,   25, 0,  16,  4, {32'hA4, 32'hA3, 32'hA2, 32'hA1}};
    vecs[3] = '{"skew_w",   0, 2, 0, -1,  -1, 0,  0,   21, 0,  4,  12, {32'hB4, 32'hB3, 32'hB2, 32'hB1}};
    vecs[4] = '{"bresp",    0, 0, 0, 1,   -1, 0,  0,   13, 1,  4,   4, {32'hC4, 32'hC3, 32'hC2, 32'hC1}};
    vecs[5] = '{"stall",    0, 0, 0, -1,  1,  5,  1,   18, 0,  4,   4, {32'hD4, 32'hD3, 32'hD2, 32'hD1}};

    repeat (3) @(posedge ap_clk);
    #1;
    chk("reset_outputs", {busy_a, done_a, err_a, tready_a, awvalid_a, wvalid_a, bready_a, awaddr_a, wdata_a}, 64'd0);
    chk("reset_wstrb", 64'(wstrb_a), 64'hF);
    @(negedge ap_clk) ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    chk("idle_after_reset", {busy_a, tready_a}, 64'd0);

    for (int r = 0; r < 6; r++) run_row(vecs[r]);

    // reset while word 2's address is still waiting for AWREADY
    arm(vecs[2]);
    aw0 = aw_n;
    pulse_start();
    cnt = 0;
    while (!(awvalid_a && (aw_n - aw0) == 2) && cnt < 300) begin
      @(posedge ap_clk); #1;
      cnt++;
    end
    chk("midload_reached_word2", 64'(awvalid_a && (aw_n - aw0) == 2), 64'd1);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {busy_a, done_a, err_a, tready_a, awvalid_a, wvalid_a, bready_a, awaddr_a, wdata_a}, 64'd0);
    chk("midreset_outputs_b", {busy_b, done_b, err_b, tready_b, awvalid_b, wvalid_b, bready_b, awaddr_b, wdata_b}, 64'd0);
    chk("midreset_wstrb", {wstrb_a, wstrb_b}, 64'hFF);
    @(posedge ap_clk);
    @(negedge ap_clk) ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    chk("post_reset_idle", {busy_a, tready_a, awvalid_a}, 64'd0);
    sn0 = s_n;
    repeat (3) @(posedge ap_clk);
    #1;
    chk("idle_stream_not_consumed", 64'(s_n - sn0), 64'd0);
    $display("reset mid-load at word 2: busy=%0d awvalid=%0d", busy_a, awvalid_a);
    run_row(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
